// File: rtl/sprite_mem_stage.sv
// Memory stage: registers execute results toward writeback and owns the
// single-ported sprite attribute RAM shared between the CPU and the display engine.
module sprite_mem_stage #(
  parameter int unsigned SPRITE_COUNT = 256,
  parameter int unsigned ATTR_COUNT   = 16,
  parameter int unsigned MAX_STARVE   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [4:0]  ex_dst_reg,
  input  logic        ex_reg_we,
  input  logic        ex_sprite_re,
  input  logic        ex_sprite_we,
  input  logic [7:0]  ex_sprite_addr,
  input  logic [3:0]  ex_sprite_fcn,
  input  logic [7:0]  ex_sprite_wdata,
  input  logic        ex_sprite_use_dst_reg,
  output logic        stall,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_dst_reg,
  output logic        wb_reg_we,
  input  logic        disp_req,
  input  logic [11:0] disp_addr,
  output logic        disp_ack,
  output logic [7:0]  disp_data
);

  localparam int unsigned DEPTH    = SPRITE_COUNT * ATTR_COUNT;
  localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);

  typedef enum logic {
    IDLE,
    RD_WAIT
  } state_t;

  state_t              state, next_state;
  logic [STARVE_W-1:0] starve_cnt, starve_next;

  logic        cpu_op;
  logic        cpu_wr;
  logic        starved;
  logic        grant_cpu;
  logic        grant_disp;
  logic        consume;
  logic [11:0] cpu_idx;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_q;
  logic [7:0]  mem [DEPTH];

  assign cpu_op  = ex_valid & (ex_sprite_re | ex_sprite_we);
  assign cpu_wr  = ex_sprite_we;
  assign cpu_idx = {ex_sprite_addr, ex_sprite_fcn};
  assign starved = (starve_cnt == STARVE_W'(MAX_STARVE));

  always_comb begin
    grant_cpu   = 1'b0;
    grant_disp  = 1'b0;
    next_state  = state;
    starve_next = '0;
    unique case (state)
      IDLE: begin
        if (cpu_op && (starved || !disp_req)) begin
          grant_cpu = 1'b1;
        end else if (disp_req) begin
          grant_disp = 1'b1;
        end
        if (grant_cpu && !cpu_wr) begin
          next_state = RD_WAIT;
        end
        if (cpu_op && grant_disp) begin
          starve_next = starved ? starve_cnt : starve_cnt + STARVE_W'(1);
        end
      end
      RD_WAIT: begin
        // The held read completes here; the port stays idle for the display.
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // In RD_WAIT the held read is the one being completed, so it never stalls.
  assign stall   = rst_n & cpu_op & (state == IDLE) & (~grant_cpu | ~cpu_wr);
  assign consume = rst_n & ex_valid & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= next_state;
      starve_cnt <= starve_next;
    end
  end

  assign ram_addr = grant_disp ? disp_addr : cpu_idx;
  assign ram_we   = rst_n & grant_cpu & cpu_wr;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ex_sprite_wdata;
    end
    ram_q <= mem[ram_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_reg_we  <= 1'b0;
      wb_data    <= '0;
      wb_dst_reg <= '0;
      disp_ack   <= 1'b0;
    end else begin
      wb_valid <= consume;
      disp_ack <= grant_disp;
      if (consume) begin
        wb_dst_reg <= ex_dst_reg;
        if (!cpu_op) begin
          wb_data   <= ex_alu_result;
          wb_reg_we <= ex_reg_we;
        end else if (cpu_wr) begin
          wb_data   <= '0;
          wb_reg_we <= 1'b0;
        end else begin
          wb_data   <= {24'b0, ram_q};
          wb_reg_we <= ex_sprite_use_dst_reg;
        end
      end else begin
        wb_reg_we <= 1'b0;
      end
    end
  end

  assign disp_data = disp_ack ? ram_q : '0;

endmodule

// File: tb/tb_sprite_mem_stage.sv
// Bench for sprite_mem_stage: directed scenarios plus randomized traffic,
// all checked against a cycle-level reference of the arbitration rules.
module tb_sprite_mem_stage;

  localparam int MAX_STARVE = 3;
  localparam logic [11:0] POOL [8] = '{12'h123, 12'h000, 12'hFFF, 12'h0F0,
                                       12'h120, 12'h7A5, 12'h001, 12'hF0F};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_alu_result = '0;
  logic [4:0]  ex_dst_reg = '0;
  logic        ex_reg_we = 1'b0;
  logic        ex_sprite_re = 1'b0;
  logic        ex_sprite_we = 1'b0;
  logic [7:0]  ex_sprite_addr = '0;
  logic [3:0]  ex_sprite_fcn = '0;
  logic [7:0]  ex_sprite_wdata = '0;
  logic        ex_sprite_use_dst_reg = 1'b0;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_dst_reg;
  logic        wb_reg_we;
  logic        disp_req = 1'b0;
  logic [11:0] disp_addr = '0;
  logic        disp_ack;
  logic [7:0]  disp_data;

  always #5 clk = ~clk;

  sprite_mem_stage #(
    .SPRITE_COUNT(256),
    .ATTR_COUNT  (16),
    .MAX_STARVE  (MAX_STARVE)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .ex_valid             (ex_valid),
    .ex_alu_result        (ex_alu_result),
    .ex_dst_reg           (ex_dst_reg),
    .ex_reg_we            (ex_reg_we),
    .ex_sprite_re         (ex_sprite_re),
    .ex_sprite_we         (ex_sprite_we),
    .ex_sprite_addr       (ex_sprite_addr),
    .ex_sprite_fcn        (ex_sprite_fcn),
    .ex_sprite_wdata      (ex_sprite_wdata),
    .ex_sprite_use_dst_reg(ex_sprite_use_dst_reg),
    .stall                (stall),
    .wb_valid             (wb_valid),
    .wb_data              (wb_data),
    .wb_dst_reg           (wb_dst_reg),
    .wb_reg_we            (wb_reg_we),
    .disp_req             (disp_req),
    .disp_addr            (disp_addr),
    .disp_ack             (disp_ack),
    .disp_data            (disp_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: memory image, pending-read flag, starvation count,
  // and the registered outputs expected after the most recent edge.
  byte unsigned ref_mem [4096];
  bit           ref_rdwait = 1'b0;
  int           ref_starve = 0;
  bit           e_wb_valid = 1'b0;
  bit           e_wb_we = 1'b0;
  bit           e_ack = 1'b0;
  logic [31:0]  e_wb_data = '0;
  logic [4:0]   e_wb_dst = '0;
  logic [7:0]   e_ddata = '0;
  bit           last_consumed = 1'b1;
  bit           last_disp_win = 1'b0;
  bit           obs_stall;
  bit           obs_ack;

  function automatic logic [11:0] pick_idx();
    if ($urandom_range(0, 1) == 0) return POOL[$urandom_range(0, 7)];
    return 12'($urandom);
  endfunction

  // Checks the current cycle at the falling edge, advances the reference
  // across the next rising edge, and returns just after that edge.
  task automatic tick();
    bit cpu, wr, cpu_win, disp_win, stall_exp, consumed;
    int idx, didx;
    @(negedge clk);
    obs_stall = stall;
    obs_ack   = disp_ack;
    if (!rst_n) begin
      ref_rdwait = 1'b0; ref_starve = 0;
      e_wb_valid = 1'b0; e_wb_we = 1'b0; e_ack = 1'b0;
      e_wb_data = '0; e_wb_dst = '0; e_ddata = '0;
      check_eq("rst_stall", stall, 0);
      check_eq("rst_wb_valid", wb_valid, 0);
      check_eq("rst_wb_data", wb_data, 0);
      check_eq("rst_wb_dst", wb_dst_reg, 0);
      check_eq("rst_wb_we", wb_reg_we, 0);
      check_eq("rst_disp_ack", disp_ack, 0);
      check_eq("rst_disp_data", disp_data, 0);
      last_consumed = 1'b0;
      last_disp_win = 1'b0;
    end else begin
      check_eq("wb_valid", wb_valid, e_wb_valid);
      check_eq("wb_data", wb_data, e_wb_data);
      check_eq("wb_dst_reg", wb_dst_reg, e_wb_dst);
      check_eq("wb_reg_we", wb_reg_we, e_wb_we);
      check_eq("disp_ack", disp_ack, e_ack);
      if (e_ack) check_eq("disp_data", disp_data, e_ddata);

      cpu  = ex_valid && (ex_sprite_re || ex_sprite_we);
      wr   = ex_sprite_we;
      idx  = int'(ex_sprite_addr) * 16 + int'(ex_sprite_fcn);
      didx = int'(disp_addr);
      cpu_win  = 1'b0;
      disp_win = 1'b0;
      if (!ref_rdwait) begin
        if (cpu && (ref_starve == MAX_STARVE || !disp_req)) cpu_win = 1'b1;
        else if (disp_req) disp_win = 1'b1;
      end
      stall_exp = cpu && !ref_rdwait && (!cpu_win || !wr);
      check_eq("stall", stall, stall_exp);
      consumed = ex_valid && !stall_exp;

      e_ack = disp_win;
      if (disp_win) e_ddata = ref_mem[didx];
      e_wb_valid = consumed;
      if (consumed) begin
        e_wb_dst = ex_dst_reg;
        if (!cpu) begin
          e_wb_data = ex_alu_result;
          e_wb_we   = ex_reg_we;
        end else if (wr) begin
          e_wb_data = 0;
          e_wb_we   = 1'b0;
        end else begin
          e_wb_data = 32'(ref_mem[idx]);
          e_wb_we   = ex_sprite_use_dst_reg;
        end
      end else begin
        e_wb_we = 1'b0;
      end
      if (cpu_win && wr) ref_mem[idx] = ex_sprite_wdata;
      if (!ref_rdwait && cpu && disp_win)
        ref_starve = (ref_starve + 1 > MAX_STARVE) ? MAX_STARVE : ref_starve + 1;
      else
        ref_starve = 0;
      ref_rdwait    = !ref_rdwait && cpu_win && !wr;
      last_consumed = consumed;
      last_disp_win = disp_win;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input bit re, input bit we, input logic [7:0] sa, input logic [3:0] fcn,
                        input logic [7:0] wd, input logic [4:0] dst, input bit use_dst);
    ex_valid = 1'b1; ex_sprite_re = re; ex_sprite_we = we;
    ex_sprite_addr = sa; ex_sprite_fcn = fcn; ex_sprite_wdata = wd;
    ex_dst_reg = dst; ex_sprite_use_dst_reg = use_dst; ex_reg_we = 1'($urandom);
    ex_alu_result = $urandom;
  endtask

  // Runs a held read until consumed; returns the number of stalled cycles.
  task automatic run_read(output int nst);
    int n = 0;
    nst = 0;
    do begin
      tick();
      if (obs_stall) nst++;
      n++;
    end while (obs_stall && n < 10);
  endtask

  // Display streams addresses 0,1,2,... while one CPU op waits behind it.
  task automatic arb_case(input bit is_read);
    logic [6:0] st, ak;
    int a = 0;
    set_op(is_read, !is_read, 8'h40, 4'h2, 8'h5E, 5'd9, 1'b1);
    disp_req = 1'b1; disp_addr = '0;
    for (int c = 0; c < 7; c++) begin
      tick();
      st[c] = obs_stall;
      ak[c] = obs_ack;
      if (last_consumed) ex_valid = 1'b0;
      if (last_disp_win) begin
        a++;
        disp_addr = 12'(a);
        if (a >= 5) disp_req = 1'b0;
      end
    end
    if (is_read) begin
      check_eq("arb_rd_stall_pattern", 32'(st), 32'b0001111);
      check_eq("arb_rd_ack_pattern", 32'(ak), 32'b1001110);
    end else begin
      check_eq("arb_wr_stall_pattern", 32'(st), 32'b0000111);
      check_eq("arb_wr_ack_pattern", 32'(ak), 32'b1101110);
    end
    disp_req = 1'b0;
    ex_valid = 1'b0;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int nst, k;

    // Reset held with random inputs.
    for (int i = 0; i < 3; i++) begin
      set_op(1'($urandom), 1'($urandom), 8'($urandom), 4'($urandom), 8'($urandom), 5'($urandom), 1'($urandom));
      disp_req = 1'($urandom); disp_addr = 12'($urandom);
      tick();
    end
    ex_valid = 1'b0; disp_req = 1'b0;
    rst_n = 1'b1;
    repeat (2) tick();

    // ALU pass-through.
    ex_valid = 1'b1; ex_sprite_re = 1'b0; ex_sprite_we = 1'b0;
    ex_alu_result = 32'h12345678; ex_dst_reg = 5'd5; ex_reg_we = 1'b1;
    tick();
    check_eq("alu_wb_valid", wb_valid, 1);
    check_eq("alu_wb_data", wb_data, 32'h12345678);
    check_eq("alu_wb_dst", wb_dst_reg, 5);
    check_eq("alu_wb_we", wb_reg_we, 1);
    ex_valid = 1'b0;
    tick();

    // Fill the whole RAM so every later read has a known value.
    for (int i = 0; i < 4096; i++) begin
      set_op(1'($urandom), 1'b1, 8'(i >> 4), 4'(i), 8'($urandom), 5'($urandom), 1'b0);
      tick();
    end
    ex_valid = 1'b0;
    tick();

    // Write immediately followed by a read of the same attribute.
    set_op(1'b0, 1'b1, 8'h12, 4'h3, 8'hA5, 5'd2, 1'b0);
    tick();
    set_op(1'b1, 1'b0, 8'h12, 4'h3, 8'h00, 5'd7, 1'b1);
    run_read(nst);
    check_eq("raw_stall_cycles", nst, 1);
    check_eq("raw_wb_valid", wb_valid, 1);
    check_eq("raw_wb_data", wb_data, 32'h000000A5);
    check_eq("raw_wb_dst", wb_dst_reg, 7);
    check_eq("raw_wb_we", wb_reg_we, 1);
    ex_valid = 1'b0;
    tick();

    arb_case(1'b0);
    arb_case(1'b1);

    // Reset asserted while a read waits in RD_WAIT (boundary index).
    set_op(1'b0, 1'b1, 8'hFF, 4'hF, 8'h3C, 5'd3, 1'b0);
    tick();
    set_op(1'b1, 1'b0, 8'hFF, 4'hF, 8'h00, 5'd11, 1'b1);
    tick();
    check_eq("midrd_first_stall", obs_stall, 1);
    rst_n = 1'b0;
    tick();
    check_eq("midrd_no_wb", wb_valid, 0);
    tick();
    rst_n = 1'b1;
    run_read(nst);
    check_eq("midrd_reissue_stall", nst, 1);
    check_eq("midrd_wb_valid", wb_valid, 1);
    check_eq("midrd_wb_data", wb_data, 32'h0000003C);
    check_eq("midrd_wb_dst", wb_dst_reg, 11);
    ex_valid = 1'b0;
    tick();

    // Random traffic with protocol-respecting holds on both requesters.
    last_consumed = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) rst_n = 1'b0;
      if (n == 1502) rst_n = 1'b1;
      if (!ex_valid || last_consumed) begin
        k = $urandom_range(0, 3);
        set_op(k == 1 || k == 3, k >= 2, 8'h00, 4'h0, 8'($urandom), 5'($urandom), 1'($urandom));
        {ex_sprite_addr, ex_sprite_fcn} = pick_idx();
        ex_valid = ($urandom_range(0, 3) != 0);
      end
      if (!disp_req || last_disp_win) begin
        disp_req  = 1'($urandom);
        disp_addr = pick_idx();
      end
      tick();
    end
    ex_valid = 1'b0; disp_req = 1'b0;
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
